// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle for fetch_decode_buffer.
// master = fetch/decode control side, slave = the buffer itself.
interface fetch_decode_buffer_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               in_ready;
  logic               dec_stall;
  logic               itr;
  logic               flush;
  logic               iw;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CW-1:0]      count;

  modport master (
    output in_valid, in_instr, in_pc, dec_stall, itr, flush, iw,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, dec_stall, itr, flush, iw,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// DEPTH-entry circular instruction queue between fetch and decode with a registered output stage.
// Optional FDB_BYPASS_EN: an empty queue forwards the input straight into the output stage (1-cycle latency).
module fetch_decode_buffer #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count_q;
  logic               flush_pend;
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [PC_W-1:0]    out_pc_q;

  logic in_ready, accept, advance, eff_flush, bypass, push, pop;

  // in_ready deliberately has no dec_stall term so fetch keeps filling during decode stalls.
  assign in_ready  = (count_q < CW'(DEPTH)) & ~bus.itr & ~bus.flush;
  assign accept    = bus.in_valid & in_ready;
  assign advance   = ~bus.dec_stall & ~bus.itr;
  assign eff_flush = bus.flush | flush_pend;

`ifdef FDB_BYPASS_EN
  assign bypass = advance & ~eff_flush & ~bus.iw & (count_q == '0) & accept;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass;
  assign pop  = advance & ~eff_flush & ~bus.iw & (count_q != '0);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.count     = count_q;

  // Storage needs no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: bus.in_instr, pc: bus.in_pc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      flush_pend  <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end

      // A flush seen while frozen is remembered and turned into a bubble on the next advance.
      if (!advance) begin
        if (bus.flush) flush_pend <= 1'b1;
      end else if (eff_flush) begin
        out_valid_q <= 1'b0;
        out_instr_q <= NOP_INSTR;
        flush_pend  <= 1'b0;
      end else if (bus.iw) begin
        out_valid_q <= 1'b0;
        out_instr_q <= NOP_INSTR;
      end else if (bypass) begin
        out_valid_q <= 1'b1;
        out_instr_q <= bus.in_instr;
        out_pc_q    <= bus.in_pc;
      end else if (count_q != '0) begin
        out_valid_q <= 1'b1;
        out_instr_q <= mem[rd_ptr].instr;
        out_pc_q    <= mem[rd_ptr].pc;
      end else begin
        out_valid_q <= 1'b0;
        out_instr_q <= NOP_INSTR;
      end
    end
  end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: accepted instructions are queued, drained against real outputs.
module tb_fetch_decode_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] KEY   = 32'hC0DE_0000;
`ifdef FDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic adv_q = 1'b0;
  ent_t sb[$];

  fetch_decode_buffer_if #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH)) bus ();

  fetch_decode_buffer #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference acceptance: room in the model queue, no freeze, no flush.
  always @(posedge clk) begin
    if (reset || bus.flush) sb.delete();
    else if (bus.in_valid && sb.size() < DEPTH && !bus.itr)
      sb.push_back('{instr: bus.in_instr, pc: bus.in_pc});
    adv_q <= !bus.dec_stall && !bus.itr && !reset;
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (adv_q && bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_spurious: out_pc=%h out_valid=1 but no instruction expected", bus.out_pc);
        end else begin
          ent_t e;
          e = sb.pop_front();
          if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
            failures++;
            $display("FAIL sb_order: got pc=%h instr=%h expected pc=%h instr=%h",
                     bus.out_pc, bus.out_instr, e.pc, e.instr);
          end
        end
      end else if (adv_q) begin
        checks++;
        if (bus.out_instr !== NOP) begin
          failures++;
          $display("FAIL bubble_nop: out_instr=%h expected %h", bus.out_instr, NOP);
        end
      end
      checks++;
      if (bus.count !== 3'(sb.size())) begin
        failures++;
        $display("FAIL sb_count: count=%0d expected %0d", bus.count, sb.size());
      end
      checks++;
      if (bus.in_ready !== ((sb.size() < DEPTH) && !bus.itr && !bus.flush)) begin
        failures++;
        $display("FAIL in_ready: got %b expected %b", bus.in_ready,
                 (sb.size() < DEPTH) && !bus.itr && !bus.flush);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(logic v, logic [31:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = pc ^ KEY;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0);
    bus.dec_stall = 1'b0;
    bus.itr       = 1'b0;
    bus.flush     = 1'b0;
    bus.iw        = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_0000);
    tick(2);
    checks += 5;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_instr !== NOP)  begin failures++; $display("FAIL rst_instr: got %h expected %h", bus.out_instr, NOP); end
    if (bus.out_pc !== 32'h0)   begin failures++; $display("FAIL rst_pc: got %h expected 0", bus.out_pc); end
    if (bus.count !== 3'd0)     begin failures++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
    if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready: got %b expected 1", bus.in_ready); end
    reset = 1'b0;
    drive(1'b0, 32'h0);
    mon_en = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      tick();
      checks++;
      if (bus.count > 3'd1) begin failures++; $display("FAIL stream_count: got %0d expected <=1", bus.count); end
      if (i == 0) begin
        checks++;
        if (bus.out_valid !== BYP) begin failures++; $display("FAIL stream_lat1: out_valid=%b expected %b", bus.out_valid, BYP); end
      end
      if (i == 1) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_lat2: out_valid=%b expected 1", bus.out_valid); end
      end
    end
    drive(1'b0, 32'h0);
    tick(3);
    checks += 3;
    if (bus.out_valid !== 1'b0)  begin failures++; $display("FAIL stream_drain_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_pc !== 32'h10C)  begin failures++; $display("FAIL stream_hold_pc: got %h expected 10c", bus.out_pc); end
    if (sb.size() != 0)          begin failures++; $display("FAIL stream_left: %0d entries never emerged", sb.size()); end
  endtask

  task automatic test_stall_fill();
    bus.dec_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      checks++;
      if (bus.in_ready !== (i < 4)) begin failures++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, bus.in_ready, i < 4); end
      tick();
    end
    drive(1'b0, 32'h0);
    checks += 3;
    if (bus.count !== 3'd4)     begin failures++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fill_hold_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_pc !== 32'h10C) begin failures++; $display("FAIL fill_hold_pc: got %h expected 10c", bus.out_pc); end
    bus.dec_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h500 + 32'(4 * i)) begin
        failures++;
        $display("FAIL fill_drain[%0d]: valid=%b pc=%h expected 1/%h", i, bus.out_valid, bus.out_pc, 32'h500 + 32'(4 * i));
      end
    end
    tick();
    checks++;
    if (bus.count !== 3'd0) begin failures++; $display("FAIL fill_empty: count=%0d expected 0", bus.count); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h200);
    tick();
`ifndef FDB_BYPASS_EN
    drive(1'b0, 32'h0);
    tick();
`endif
    bus.dec_stall = 1'b1;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 32'h0);
    checks += 2;
    if (bus.count !== 3'd3) begin failures++; $display("FAIL flush_pre_count: got %0d expected 3", bus.count); end
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
      failures++; $display("FAIL flush_pre_out: valid=%b pc=%h expected 1/200", bus.out_valid, bus.out_pc);
    end
    bus.dec_stall = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks += 4;
    if (bus.count !== 3'd0)     begin failures++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_instr !== NOP)  begin failures++; $display("FAIL flush_instr: got %h expected %h", bus.out_instr, NOP); end
    if (bus.out_pc !== 32'h200) begin failures++; $display("FAIL flush_pc: got %h expected 200", bus.out_pc); end
  endtask

  task automatic test_pending_flush();
    drive(1'b1, 32'h2F0);
    tick();
`ifndef FDB_BYPASS_EN
    drive(1'b0, 32'h0);
    tick();
`endif
    bus.dec_stall = 1'b1;
    drive(1'b1, 32'h2F4);
    tick();
    drive(1'b0, 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks += 2;
    if (bus.count !== 3'd0) begin failures++; $display("FAIL pend_count: got %0d expected 0", bus.count); end
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h2F0) begin
      failures++; $display("FAIL pend_hold: valid=%b pc=%h expected 1/2f0", bus.out_valid, bus.out_pc);
    end
    drive(1'b1, 32'h300);
    tick();
    drive(1'b0, 32'h0);
    bus.dec_stall = 1'b0;
    tick();
    checks += 3;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP) begin
      failures++; $display("FAIL pend_bubble: valid=%b instr=%h expected 0/%h", bus.out_valid, bus.out_instr, NOP);
    end
    if (bus.out_pc !== 32'h2F0) begin failures++; $display("FAIL pend_bubble_pc: got %h expected 2f0", bus.out_pc); end
    if (bus.count !== 3'd1)     begin failures++; $display("FAIL pend_survivor: count=%0d expected 1", bus.count); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin
      failures++; $display("FAIL pend_next: valid=%b pc=%h expected 1/300", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_iw();
    bus.dec_stall = 1'b1;
    drive(1'b1, 32'h600); tick();
    drive(1'b1, 32'h604); tick();
    drive(1'b0, 32'h0);
    bus.dec_stall = 1'b0;
    bus.iw        = 1'b1;
    tick();
    bus.iw = 1'b0;
    checks += 3;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP) begin
      failures++; $display("FAIL iw_bubble: valid=%b instr=%h expected 0/%h", bus.out_valid, bus.out_instr, NOP);
    end
    if (bus.out_pc !== 32'h300) begin failures++; $display("FAIL iw_pc: got %h expected 300", bus.out_pc); end
    if (bus.count !== 3'd2)     begin failures++; $display("FAIL iw_count: got %0d expected 2", bus.count); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h600) begin
      failures++; $display("FAIL iw_head: valid=%b pc=%h expected 1/600", bus.out_valid, bus.out_pc);
    end
    tick();
  endtask

  task automatic test_bypass();
    tick(2);
    drive(1'b1, 32'h400);
    tick();
    drive(1'b0, 32'h0);
`ifdef FDB_BYPASS_EN
    checks += 2;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h400) begin
      failures++; $display("FAIL byp_out: valid=%b pc=%h expected 1/400", bus.out_valid, bus.out_pc);
    end
    if (bus.count !== 3'd0) begin failures++; $display("FAIL byp_count: got %0d expected 0", bus.count); end
`else
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL nobyp_lat1: valid=%b expected 0", bus.out_valid); end
    if (bus.count !== 3'd1)     begin failures++; $display("FAIL nobyp_count: got %0d expected 1", bus.count); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h400) begin
      failures++; $display("FAIL nobyp_out: valid=%b pc=%h expected 1/400", bus.out_valid, bus.out_pc);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dec_stall = 1'b1;
    drive(1'b1, 32'h700); tick();
    drive(1'b1, 32'h704); tick();
    reset = 1'b1;
    tick();
    checks += 3;
    if (bus.count !== 3'd0)     begin failures++; $display("FAIL rmid_count: got %0d expected 0", bus.count); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_pc !== 32'h0)   begin failures++; $display("FAIL rmid_pc: got %h expected 0", bus.out_pc); end
    reset = 1'b0;
    idle();
    tick(2);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, 32'h1000 + 32'(4 * k));
      bus.dec_stall = ($urandom_range(0, 3) == 0);
      bus.itr       = ($urandom_range(0, 9) == 0);
      bus.iw        = ($urandom_range(0, 9) == 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    idle();
    tick(8);
    checks++;
    if (sb.size() != 0 || bus.count !== 3'd0) begin
      failures++; $display("FAIL b2b_drain: %0d expected entries left, count=%0d", sb.size(), bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush();
    test_pending_flush();
    test_iw();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Parametrised successor to the single-entry fetch/decode pipeline register.
- A DEPTH-entry circular instruction queue between fetch and decode, feeding a registered decode-side output stage.
- Supports stall/interrupt freeze, flush with NOP injection, wait-bubble insertion, and a pending-flush latch so a flush raised during a freeze is not lost.
- Decouples fetch from short decode stalls.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, PC width in bits.
- DEPTH, 4, queue entries; power of 2, >= 2.
- NOP_INSTR, 32'h0000_0000, encoding injected as a bubble; bound to the team NOP encoding at instantiation.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of the fetched instruction.
- in_ready  out  1  queue can accept this cycle.
- dec_stall  in  1  decode stall; freezes the output stage.
- itr  in  1  interrupt freeze; freezes the output stage and blocks enqueue.
- flush  in  1  discard all queued and in-stage instructions.
- iw  in  1  instruction-wait; insert one bubble without popping.
- out_valid  out  1  out_instr is a real instruction.
- out_instr  out  INSTR_W  instruction to decode.
- out_pc  out  PC_W  PC to decode.
- count  out  $clog2(DEPTH+1)  queue occupancy, excluding the output stage.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high and overrides everything. Reset values:
  - wr_ptr = rd_ptr = 0, count = 0
  - out_valid = 0, out_instr = NOP_INSTR, out_pc = 0
  - flush_pend = 0
- in_ready = (count < DEPTH) & ~itr & ~flush. It depends only on registered count and the itr/flush inputs; there is no path from dec_stall.
- Enqueue occurs when in_valid & in_ready: write the entry at wr_ptr, then increment wr_ptr modulo DEPTH.
- Define advance = ~dec_stall & ~itr, and eff_flush = flush | flush_pend.
- Output stage, evaluated in priority order:
  1. ~advance: out_* hold. If flush=1, set flush_pend.
  2. advance & eff_flush: out_instr=NOP_INSTR, out_valid=0, out_pc holds; clear flush_pend.
  3. advance & iw: out_instr=NOP_INSTR, out_valid=0, out_pc holds; no pop.
  4. advance & count>0: pop the head into out_*; out_valid=1; rd_ptr increments modulo DEPTH.
  5. advance & count==0: out_instr=NOP_INSTR, out_valid=0, out_pc holds.
- Queue flush: flush=1 resets rd_ptr = wr_ptr = 0 and count = 0 in the same cycle, regardless of dec_stall or itr. No enqueue occurs that cycle because in_ready=0.
- Pending flush: flush_pend only affects the output stage on the next advance cycle. Entries enqueued while flush_pend=1 survive; they follow the flush in program order.
- Occupancy: count_next = count + push - pop.
  - Simultaneous push and pop at count==DEPTH is impossible (in_ready=0).
  - Push and pop in the same cycle at 0 < count < DEPTH leaves count unchanged.
- Latency: minimum 2 cycles from enqueue to out_valid, with no bypass.
- Pointers wrap DEPTH-1 -> 0 with no lost or duplicated entries.
- Reset asserted mid-operation drops all contents next edge.

Optional Feature:
- FDB_BYPASS_EN defined:
  - When advance & ~eff_flush & ~iw & count==0 & in_valid & in_ready, the input is written directly to out_* (out_valid=1) and is not enqueued.
  - Latency drops to 1 cycle.
- Undefined: all instructions pass through the queue, giving the 2-cycle minimum latency.

Test Plan:
- Reset, then stream PCs 0x100, 0x104, 0x108, 0x10C with no stalls -> out_valid rises 2 cycles after first accept; out_pc sequence 0x100..0x10C in order; count never exceeds 1.
- Hold dec_stall=1 while pushing 6 instructions (DEPTH=4) -> in_ready drops after 4 accepts; count=4; out_* unchanged; release -> 4 entries emerge in order; pointers wrap correctly.
- count=3, out_pc=0x200 valid; pulse flush for 1 cycle -> next cycle count=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0x200.
- dec_stall=1 with flush pulsed mid-stall, then push 0x300 during stall; release -> first advance emits a NOP with out_valid=0, then 0x300 with out_valid=1.
- iw=1 for 1 cycle with count=2 -> one NOP bubble; count stays 2; the next cycle pops the original head.
- With FDB_BYPASS_EN, empty queue, push 0x400 -> out_pc=0x400, out_valid=1 the next cycle; count stays 0. Without the macro -> appears 2 cycles after the push.
